// File: rtl/mile_counter.sv
// Taxi meter odometer: counts distance units from wheel pulses and
// waiting units from idle seconds, per trip.
module mile_counter #(
    parameter int PPU      = 10,
    parameter int WAIT_SEC = 60
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        WHEEL,
    input  logic        TICK,
    output logic [12:0] Mile,
    output logic [7:0]  Wait,
    output logic        Running
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [7:0]  PCNT_MAX = 8'(PPU - 1);
    localparam logic [7:0]  SCNT_MAX = 8'(WAIT_SEC - 1);
    localparam logic [12:0] MILE_MAX = 13'h1FFF;
    localparam logic [7:0]  WAIT_MAX = 8'hFF;

    state_t      state;
    state_t      state_nx;
    logic        sync1;
    logic        sync2;
    logic        wedge;
    logic        wevt;
    logic        armed;
    logic [1:0]  fill;
    logic [7:0]  pcnt;
    logic [7:0]  scnt;
    logic        trip_start;
    logic        counting;

    // A rise only counts once a genuine low has been sampled after reset,
    // so a wheel already high at release never yields a spurious pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            wedge <= 1'b0;
            wevt  <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'b00;
        end else begin
            sync1 <= WHEEL;
            sync2 <= sync1;
            wedge <= sync2;
            fill  <= {fill[0], 1'b1};
            if (fill[1] && !sync2)
                armed <= 1'b1;
            wevt  <= sync2 & ~wedge & armed;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (START)  state_nx = RUN;
            RUN:     if (!START) state_nx = HOLD;
            HOLD:    if (START)  state_nx = RUN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Running = (state == RUN);
    end

    assign trip_start = (state != RUN) && (state_nx == RUN);
    assign counting   = (state == RUN) && (state_nx == RUN);

    // Wheel activity wins over the second strobe and restarts the idle count.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Mile <= '0;
            Wait <= '0;
            pcnt <= '0;
            scnt <= '0;
        end else if (trip_start) begin
            Mile <= '0;
            Wait <= '0;
            pcnt <= '0;
            scnt <= '0;
        end else if (counting) begin
            if (wevt) begin
                scnt <= '0;
                if (pcnt == PCNT_MAX) begin
                    pcnt <= '0;
                    if (Mile != MILE_MAX)
                        Mile <= Mile + 13'd1;
                end else begin
                    pcnt <= pcnt + 8'd1;
                end
            end else if (TICK) begin
                if (scnt == SCNT_MAX) begin
                    scnt <= '0;
                    if (Wait != WAIT_MAX)
                        Wait <= Wait + 8'd1;
                end else begin
                    scnt <= scnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mile_counter.sv
// Scoreboard bench for mile_counter: trip-level reference model plus a
// second fast-parameter instance for saturation limits.
`timescale 1ns/1ps
module tb_mile_counter;

    localparam int PPU  = 10;
    localparam int WS   = 60;
    localparam int PPU2 = 2;
    localparam int WS2  = 2;

    logic        CLK = 1'b1;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic        WHEEL = 1'b0;
    logic        TICK = 1'b0;
    logic [12:0] Mile;
    logic [7:0]  Wait;
    logic        Running;

    logic        rst2 = 1'b0;
    logic        start2 = 1'b0;
    logic        wheel2 = 1'b0;
    logic        tick2 = 1'b0;
    logic [12:0] mile2;
    logic [7:0]  wait2;
    logic        running2;

    always #5 CLK = ~CLK;

    mile_counter #(.PPU(PPU), .WAIT_SEC(WS)) dut (
        .CLK(CLK), .RST(RST), .START(START), .WHEEL(WHEEL), .TICK(TICK),
        .Mile(Mile), .Wait(Wait), .Running(Running)
    );

    mile_counter #(.PPU(PPU2), .WAIT_SEC(WS2)) dut_sat (
        .CLK(CLK), .RST(rst2), .START(start2), .WHEEL(wheel2), .TICK(tick2),
        .Mile(mile2), .Wait(wait2), .Running(running2)
    );

    typedef struct {
        int mile;
        int wt;
        int run;
    } exp_t;

    exp_t sbq[$];
    bit   ws[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   m_mode = 0;
    int   m_pulses = 0;
    int   m_waits = 0;
    int   m_idle = 0;

    function automatic void check(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Trip model: distance = whole units of pulses seen this trip, waiting =
    // whole WS-second blocks of uninterrupted idle time. Pulses land 3 edges
    // after the first edge that samples the wheel high.
    task automatic model_edge();
        bit   ev;
        int   j;
        exp_t e;
        if (RST) begin
            m_mode = 0; m_pulses = 0; m_waits = 0; m_idle = 0;
            ws.delete();
        end else begin
            ws.push_back(WHEEL);
            j = ws.size() - 1;
            ev = (j >= 4) && ws[j-3] && !ws[j-4];
            case (m_mode)
                0, 2: if (START) begin
                    m_mode = 1; m_pulses = 0; m_waits = 0; m_idle = 0;
                end
                1: if (!START) m_mode = 2;
                   else if (ev) begin
                       m_idle = 0;
                       m_pulses++;
                   end else if (TICK) begin
                       m_idle++;
                       if (m_idle % WS == 0) m_waits++;
                   end
                default: ;
            endcase
        end
        e.mile = (m_pulses / PPU > 8191) ? 8191 : m_pulses / PPU;
        e.wt   = (m_waits > 255) ? 255 : m_waits;
        e.run  = (m_mode == 1) ? 1 : 0;
        sbq.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("mile", int'(Mile), e.mile);
                check("wait", int'(Wait), e.wt);
                check("running", int'(Running), e.run);
            end
        end
    end

    task automatic cyc(input bit s, input bit w, input bit t);
        START = s; WHEEL = w; TICK = t;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    task automatic pulses(input int n, input bit s);
        repeat (n) begin
            repeat (3) cyc(s, 1'b1, 1'b0);
            repeat (3) cyc(s, 1'b0, 1'b0);
        end
    endtask

    task automatic ticks(input int n, input bit s, input int gap);
        repeat (n) begin
            cyc(s, 1'b0, 1'b1);
            repeat (gap - 1) cyc(s, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n, input bit s);
        repeat (n) cyc(s, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n, input bit s, input bit w);
        #2 RST = 1'b1;
        #1;
        check("rst_mile", int'(Mile), 0);
        check("rst_wait", int'(Wait), 0);
        check("rst_running", int'(Running), 0);
        repeat (n) cyc(s, w, 1'b0);
        RST = 1'b0;
    endtask

    initial begin
        @(negedge CLK);
        fork
            begin
                bit s;
                do_reset(3, 1'b0, 1'b0);
                idle(5, 1'b0);
                pulses(3, 1'b0);
                ticks(5, 1'b0, 2);
                cyc(1'b1, 1'b0, 1'b0);
                pulses(30, 1'b1);
                idle(6, 1'b1);
                ticks(125, 1'b1, 2);
                idle(2, 1'b0);
                cyc(1'b1, 1'b0, 1'b0);
                ticks(99, 1'b1, 2);
                pulses(1, 1'b1);
                ticks(26, 1'b1, 2);
                idle(4, 1'b1);
                idle(2, 1'b0);
                cyc(1'b1, 1'b0, 1'b0);
                ticks(59, 1'b1, 1);
                repeat (3) cyc(1'b1, 1'b1, 1'b0);
                cyc(1'b1, 1'b0, 1'b1);
                idle(2, 1'b1);
                ticks(59, 1'b1, 1);
                ticks(1, 1'b1, 1);
                idle(2, 1'b0);
                cyc(1'b1, 1'b0, 1'b0);
                pulses(50, 1'b1);
                idle(4, 1'b1);
                idle(1, 1'b0);
                pulses(20, 1'b0);
                ticks(200, 1'b0, 1);
                cyc(1'b1, 1'b0, 1'b0);
                idle(3, 1'b1);
                s = 1'b1;
                repeat (300) begin
                    int hi;
                    int lo;
                    if ($urandom_range(0, 19) == 0) s = ~s;
                    if ($urandom_range(0, 9) == 0) begin
                        ticks($urandom_range(50, 130), s, 1);
                    end else begin
                        hi = $urandom_range(3, 6);
                        lo = $urandom_range(3, 6);
                        repeat (hi) cyc(s, 1'b1, $urandom_range(0, 3) == 0);
                        repeat (lo) cyc(s, 1'b0, $urandom_range(0, 3) == 0);
                    end
                end
                idle(2, 1'b0);
                cyc(1'b1, 1'b0, 1'b0);
                pulses(15, 1'b1);
                repeat (4) cyc(1'b1, 1'b1, 1'b0);
                do_reset(2, 1'b1, 1'b1);
                repeat (10) cyc(1'b1, 1'b1, 1'b0);
                idle(3, 1'b1);
                pulses(9, 1'b1);
                idle(5, 1'b1);
                pulses(1, 1'b1);
                idle(5, 1'b1);
            end
            begin
                #2 rst2 = 1'b1;
                #1;
                check("sat_rst_mile", int'(mile2), 0);
                @(negedge CLK);
                rst2 = 1'b0;
                start2 = 1'b1;
                @(negedge CLK);
                check("sat_running", int'(running2), 1);
                tick2 = 1'b1;
                repeat (254 * WS2) @(negedge CLK);
                tick2 = 1'b0;
                @(negedge CLK);
                check("sat_wait_254", int'(wait2), 254);
                tick2 = 1'b1;
                repeat (WS2) @(negedge CLK);
                tick2 = 1'b0;
                @(negedge CLK);
                check("sat_wait_255", int'(wait2), 255);
                tick2 = 1'b1;
                repeat (20) @(negedge CLK);
                tick2 = 1'b0;
                @(negedge CLK);
                check("sat_wait_hold", int'(wait2), 255);
                repeat (8190 * PPU2) begin
                    wheel2 = 1'b1; @(negedge CLK);
                    wheel2 = 1'b0; @(negedge CLK);
                end
                repeat (4) @(negedge CLK);
                check("sat_mile_8190", int'(mile2), 8190);
                repeat (PPU2) begin
                    wheel2 = 1'b1; @(negedge CLK);
                    wheel2 = 1'b0; @(negedge CLK);
                end
                repeat (4) @(negedge CLK);
                check("sat_mile_8191", int'(mile2), 8191);
                repeat (10) begin
                    wheel2 = 1'b1; @(negedge CLK);
                    wheel2 = 1'b0; @(negedge CLK);
                end
                repeat (4) @(negedge CLK);
                check("sat_mile_hold", int'(mile2), 8191);
                check("sat_wait_final", int'(wait2), 255);
            end
        join
        repeat (2) @(negedge CLK);
        check("sb_drain", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mile_counter.md
MILE_COUNTER -- requirements
Module: mile_counter

Interface
REQ-001 SHALL have parameter PPU, default 10: wheel-sensor pulses per distance unit (legal range 2..255).
REQ-002 SHALL have parameter WAIT_SEC, default 60: consecutive TICK strobes with no wheel pulse per waiting unit (legal range 2..255).
REQ-003 SHALL have port CLK  input  1  system clock, all state updates on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port START  input  1  synchronous level; 1 = meter engaged (passenger aboard), 0 = trip ended.
REQ-006 SHALL have port WHEEL  input  1  asynchronous wheel-sensor pulse, each pulse at least 3 CLK periods high and 3 CLK periods low.
REQ-007 SHALL have port TICK  input  1  synchronous one-cycle strobe, once per second.
REQ-008 SHALL have port Mile  output  13  distance units of the current trip; it feeds the downstream fare stage directly.
REQ-009 SHALL have port Wait  output  8  waiting units of the current trip.
REQ-010 SHALL have port Running  output  1  1 while the state is RUN.

Function
REQ-011 SHALL pass WHEEL through a 2-flop synchronizer, then a rising-edge detector producing one-cycle wevt.
REQ-012 SHALL generate wevt 2 edges after the edge that first samples WHEEL=1; the edge after wevt updates the counters (3-cycle latency).
REQ-013 SHALL implement a state machine with states IDLE, RUN and HOLD; the state is IDLE after reset.
REQ-014 SHALL transition IDLE->RUN when START=1; on that same edge it SHALL clear Mile, Wait, pcnt and scnt.
REQ-015 SHALL transition RUN->HOLD when START=0; in HOLD, Mile and Wait are frozen and wevt and TICK are ignored.
REQ-016 SHALL transition HOLD->RUN when START=1; on that same edge it SHALL clear Mile, Wait, pcnt and scnt (new trip).
REQ-017 SHALL ignore wevt and TICK in IDLE; Mile and Wait keep their values.
REQ-018 SHALL, in RUN on wevt, increment pulse counter pcnt (8-bit); when pcnt=PPU-1, pcnt SHALL go to 0 and Mile SHALL increment by 1 on the same edge.
REQ-019 SHALL saturate Mile at 8191; further unit completions leave it at 8191 while pcnt continues to wrap.
REQ-020 SHALL, in RUN, clear idle-second counter scnt (8-bit) on wevt, and SHALL increment scnt on TICK when wevt is absent.
REQ-021 SHALL, in RUN on TICK without wevt, set scnt to 0 and increment Wait when scnt=WAIT_SEC-1; Wait SHALL saturate at 255.
REQ-022 SHALL give wevt priority when wevt and TICK occur in the same cycle: scnt clears, there is no scnt increment, and Wait is unchanged.
REQ-023 SHALL count nothing on the edge where START changes state, i.e. when wevt or TICK coincides with a state transition.
REQ-024 SHALL assert Running combinationally from the state register, with no extra latency.
REQ-025 SHALL drive Mile and Wait straight from registers (glitch-free), so the downstream stage samples them on any edge.

Reset
REQ-026 SHALL, while RST=1, immediately force state=IDLE, Mile=0, Wait=0, Running=0, pcnt=0, scnt=0, and clear both synchronizer flops and the edge-detect flop.
REQ-027 SHALL, on reset asserted mid-trip, lose all counts; after release the block stays in IDLE until an edge samples START=1.
REQ-028 SHALL NOT produce wevt on the first edge after RST release, even with WHEEL already high; the first count requires a fresh low-to-high transition.

Verification
REQ-029 SHALL cover: reset, START=1, 30 WHEEL pulses (PPU=10) -> Mile=3 and Running=1; the third unit appears 3 edges after the 30th pulse rises.
REQ-030 SHALL cover: in RUN with no WHEEL, 125 TICKs (WAIT_SEC=60) -> Wait=2 and Mile unchanged; a WHEEL pulse at TICK 100 instead yields Wait=1.
REQ-031 SHALL cover: wevt and TICK in the same cycle with scnt=59 -> Wait unchanged and scnt=0.
REQ-032 SHALL cover: Mile=8191 with 10 more pulses -> Mile stays 8191 and pcnt wraps to 0.
REQ-033 SHALL cover: Mile=5, START 1->0 -> HOLD, with Mile=5 held through 20 pulses and 200 TICKs; START 0->1 -> Mile=0, Wait=0 and Running=1.
REQ-034 SHALL cover: RST pulsed mid-trip with WHEEL held high -> outputs 0 asynchronously, and there is no count after release until WHEEL falls and rises again with START=1.
